// File: rtl/rtc_bus_sched_if.sv
// RTC AD-bus scheduler interface: request side and multiplexed AD bus side.
interface rtc_bus_sched_if;
  logic       req_lec;
  logic       req_esc;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       A_D;
  logic       CS_n;
  logic       RD_n;
  logic       WR_n;
  logic [7:0] rdata;
  logic       done_lec;
  logic       done_esc;
  logic       busy;

  modport master (
    output req_lec, req_esc, addr, wdata, ad_in,
    input  ad_out, ad_oe, A_D, CS_n, RD_n, WR_n, rdata, done_lec, done_esc, busy
  );

  modport slave (
    input  req_lec, req_esc, addr, wdata, ad_in,
    output ad_out, ad_oe, A_D, CS_n, RD_n, WR_n, rdata, done_lec, done_esc, busy
  );
endinterface

// File: rtl/rtc_bus_sched.sv
// RTC AD-bus scheduler: arbitrates VGA-refresh reads against user writes and
// sequences one multiplexed address/gap/data transaction at a time.
module rtc_bus_sched #(
  parameter int T_PHASE = 14,
  parameter int T_GAP   = 14
) (
  input  logic            clk,
  input  logic            reset,
  rtc_bus_sched_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ADDR, GAP, DATA, FIN} state_t;

  localparam logic [6:0] PH_LAST  = 7'(T_PHASE - 1);
  localparam logic [6:0] GAP_LAST = 7'(T_GAP - 1);
  localparam logic [6:0] STB_LO   = 7'd2;
  localparam logic [6:0] STB_HI   = 7'(T_PHASE - 3);

  state_t     state, stateNxt;
  logic [6:0] cnt;
  logic       opWrite;     // captured operation: 1 = write
  logic       lastWrite;   // last grant went to the write path
  logic [7:0] addrQ, wdataQ, rdataQ;
  logic       grantWrite;
  logic       strobeWin;

  // Round-robin pick; lastWrite=0 after reset gives write the first win.
  assign grantWrite = bus.req_esc && (!bus.req_lec || !lastWrite);
  assign strobeWin  = (cnt >= STB_LO) && (cnt <= STB_HI);

  // Next-state logic: fixed-length phases timed by the phase counter.
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (bus.req_lec || bus.req_esc) stateNxt = ADDR;
      ADDR:    if (cnt == PH_LAST)  stateNxt = GAP;
      GAP:     if (cnt == GAP_LAST) stateNxt = DATA;
      DATA:    if (cnt == PH_LAST)  stateNxt = FIN;
      FIN:     stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // State, phase counter, grant capture and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      opWrite   <= 1'b0;
      lastWrite <= 1'b0;
      addrQ     <= '0;
      wdataQ    <= '0;
      rdataQ    <= '0;
    end else begin
      state <= stateNxt;
      if (stateNxt != state)
        cnt <= '0;
      else if (state == ADDR || state == GAP || state == DATA)
        cnt <= cnt + 7'd1;
      if (state == IDLE && stateNxt == ADDR) begin
        opWrite   <= grantWrite;
        lastWrite <= grantWrite;
        addrQ     <= bus.addr;
        wdataQ    <= bus.wdata;
      end
      // Sample late in the read strobe so the RTC has had time to drive.
      if (state == DATA && !opWrite && cnt == STB_HI)
        rdataQ <= bus.ad_in;
    end
  end

  // Bus outputs decoded from state and counter.
  always_comb begin
    bus.A_D      = 1'b0;
    bus.ad_oe    = 1'b0;
    bus.ad_out   = 8'h00;
    bus.CS_n     = 1'b1;
    bus.RD_n     = 1'b1;
    bus.WR_n     = 1'b1;
    bus.done_lec = 1'b0;
    bus.done_esc = 1'b0;
    case (state)
      ADDR: begin
        bus.ad_oe  = 1'b1;
        bus.ad_out = addrQ;
        bus.CS_n   = !strobeWin;
        bus.WR_n   = !strobeWin;
      end
      GAP: begin
        // ADDR always ends with the bus driven, so holding means driving.
        bus.A_D    = 1'b1;
        bus.ad_oe  = 1'b1;
        bus.ad_out = addrQ;
      end
      DATA: begin
        bus.A_D  = 1'b1;
        bus.CS_n = !strobeWin;
        if (opWrite) begin
          bus.ad_oe  = 1'b1;
          bus.ad_out = wdataQ;
          bus.WR_n   = !strobeWin;
        end else begin
          bus.ad_out = addrQ;
          bus.RD_n   = !strobeWin;
        end
      end
      FIN: begin
        bus.done_lec = !opWrite;
        bus.done_esc = opWrite;
      end
      default: ;
    endcase
  end

  assign bus.busy  = (state != IDLE);
  assign bus.rdata = rdataQ;

endmodule

// File: tb/tb_rtc_bus_sched.sv
// Bench for rtc_bus_sched: timeline reference model plus directed scenarios.
module tb_rtc_bus_sched;
  localparam int TP   = 14;
  localparam int TG   = 14;
  localparam int TFIN = 2*TP + TG + 1;

  logic clk = 1'b0;
  logic reset, reset1;
  always #5 clk = ~clk;

  rtc_bus_sched_if bus0();
  rtc_bus_sched_if bus1();

  rtc_bus_sched dut0 (.clk(clk), .reset(reset), .bus(bus0));
  rtc_bus_sched #(.T_PHASE(6), .T_GAP(1)) dut1 (.clk(clk), .reset(reset1), .bus(bus1));

  int nCmp = 0;
  int nErr = 0;

  // Reference model: t = cycles since grant (0 = idle, TFIN = completion cycle).
  int         t = 0;
  bit         mW, mLastW, mValid = 0;
  logic [7:0] mAddr, mWdata, mRdata;

  always @(posedge clk) begin
    if (reset) begin
      t = 0; mLastW = 0; mW = 0; mAddr = 0; mWdata = 0; mRdata = 0; mValid = 1;
    end else begin
      if (t > TP+TG && t <= 2*TP+TG && !mW && (t-1-TP-TG) == TP-3) mRdata = bus0.ad_in;
      if (t == 0) begin
        if (bus0.req_esc || bus0.req_lec) begin
          mW = bus0.req_esc && (!bus0.req_lec || !mLastW);
          mLastW = mW; mAddr = bus0.addr; mWdata = bus0.wdata; t = 1;
        end
      end else if (t == TFIN) t = 0;
      else t++;
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    logic [23:0] e, a;
    int  k;
    bit  st;
    if (mValid) begin
      e = {8'b0000_0111, 8'h00, mRdata};
      if (t >= 1 && t <= TP) begin
        k = t-1; st = (k >= 2 && k <= TP-3);
        e[23:16] = {1'b1, 2'b00, 1'b0, 1'b1, !st, 1'b1, !st}; e[15:8] = mAddr;
      end else if (t > TP && t <= TP+TG) begin
        e[23:16] = 8'b1001_1111; e[15:8] = mAddr;
      end else if (t > TP+TG && t <= 2*TP+TG) begin
        k = t-1-TP-TG; st = (k >= 2 && k <= TP-3);
        if (mW) begin e[23:16] = {4'b1001, 1'b1, !st, 1'b1, !st}; e[15:8] = mWdata; end
        else    begin e[23:16] = {4'b1001, 1'b0, !st, !st, 1'b1}; e[15:8] = mAddr;  end
      end else if (t == TFIN) begin
        e[23:16] = {1'b1, !mW, mW, 5'b00111};
      end
      a = {bus0.busy, bus0.done_lec, bus0.done_esc, bus0.A_D, bus0.ad_oe,
           bus0.CS_n, bus0.RD_n, bus0.WR_n, bus0.ad_out, bus0.rdata};
      nCmp++;
      if (a !== e) begin
        nErr++;
        $display("FAIL model t=%0d got %h want %h", t, a, e);
      end
      nCmp++;
      if ((!bus0.RD_n && !bus0.WR_n) || ((!bus0.RD_n || !bus0.WR_n) && bus0.CS_n)) begin
        nErr++;
        $display("FAIL strobe-excl got CS=%b RD=%b WR=%b want exclusive inside CS",
                 bus0.CS_n, bus0.RD_n, bus0.WR_n);
      end
    end
  end

  task automatic tick();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic check(input string name, input int got, input int want);
    nCmp++;
    if (got !== want) begin
      nErr++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // One dut0 transaction; request dropped after the grant edge.
  task automatic txn(input bit w, input logic [7:0] a, d, adin, input int chgAt, rstAt,
                     output int doneAt, output int kind, output int ado5, ado35,
                     output int rdLow, wrLow);
    bus0.addr = a; bus0.wdata = d; bus0.ad_in = adin;
    if (w) bus0.req_esc = 1; else bus0.req_lec = 1;
    doneAt = -1; kind = 0; ado5 = 0; ado35 = 0; rdLow = 0; wrLow = 0;
    for (int n = 1; n <= 80 && doneAt < 0; n++) begin
      tick();
      bus0.req_esc = 0; bus0.req_lec = 0;
      if (bus0.done_esc) begin doneAt = n; kind = 1; end
      if (bus0.done_lec) begin doneAt = n; kind = 2; end
      if (!bus0.RD_n) rdLow++;
      if (!bus0.WR_n) wrLow++;
      if (n == 5)  ado5  = bus0.ad_out;
      if (n == 35) ado35 = bus0.ad_out;
      if (n == chgAt) bus0.addr = 8'h30;
      if (n == rstAt) reset = 1;
      if (n == rstAt + 1) begin
        reset = 0;
        check("rst-busy", bus0.busy, 0);
        check("rst-strobes", {bus0.CS_n, bus0.RD_n, bus0.WR_n}, 3'b111);
        check("rst-oe", bus0.ad_oe, 0);
        check("rst-rdata", bus0.rdata, 0);
      end
    end
    tick();
  endtask

  initial begin
    int doneAt, kind, ado5, ado35, rdLow, wrLow, csLow, firstLow;
    int dn, dTimes[4], dKinds[4];
    bus0.req_lec = 0; bus0.req_esc = 0; bus0.addr = 0; bus0.wdata = 0; bus0.ad_in = 0;
    bus1.req_lec = 0; bus1.req_esc = 0; bus1.addr = 0; bus1.wdata = 0; bus1.ad_in = 0;
    reset = 1; reset1 = 1;
    @(negedge clk); tick();
    reset = 0; reset1 = 0;
    check("reset-busy", bus0.busy, 0);
    check("reset-outs", {bus0.CS_n, bus0.RD_n, bus0.WR_n, bus0.ad_oe, bus0.A_D}, 5'b11100);
    check("reset-adout", bus0.ad_out, 0);
    check("reset-rdata", bus0.rdata, 0);

    // Single read.
    txn(0, 8'h21, 8'h00, 8'h59, -1, -1, doneAt, kind, ado5, ado35, rdLow, wrLow);
    check("rd-done-cycle", doneAt, 43);
    check("rd-done-kind", kind, 2);
    check("rd-rdata", bus0.rdata, 8'h59);
    check("rd-addr-out", ado5, 8'h21);
    check("rd-wr-low", wrLow, 10);
    check("rd-rd-low", rdLow, 10);

    // Single write.
    txn(1, 8'h22, 8'h07, 8'hAA, -1, -1, doneAt, kind, ado5, ado35, rdLow, wrLow);
    check("wr-done-cycle", doneAt, 43);
    check("wr-done-kind", kind, 1);
    check("wr-addr-out", ado5, 8'h22);
    check("wr-data-out", ado35, 8'h07);
    check("wr-rd-low", rdLow, 0);
    check("wr-wr-low", wrLow, 20);

    // Address change during GAP is ignored.
    txn(0, 8'h21, 8'h00, 8'h44, 20, -1, doneAt, kind, ado5, ado35, rdLow, wrLow);
    check("chg-data-adout", ado35, 8'h21);
    check("chg-rdata", bus0.rdata, 8'h44);
    check("chg-done-cycle", doneAt, 43);

    // Reset at DATA counter value 5 (cycle 34).
    txn(1, 8'h55, 8'h66, 8'h00, -1, 34, doneAt, kind, ado5, ado35, rdLow, wrLow);
    check("abort-no-done", doneAt, -1);

    // Both requests held from reset: write, read, write, read.
    reset = 1; tick(); reset = 0;
    bus0.req_esc = 1; bus0.req_lec = 1;
    dn = 0;
    for (int n = 1; n <= 250 && dn < 4; n++) begin
      tick();
      if (bus0.done_esc || bus0.done_lec) begin
        dTimes[dn] = n; dKinds[dn] = bus0.done_esc ? 1 : 2; dn++;
      end
    end
    bus0.req_esc = 0; bus0.req_lec = 0;
    check("rr-count", dn, 4);
    for (int i = 0; i < 4; i++) begin
      check("rr-kind", (i < dn) ? dKinds[i] : 0, (i % 2 == 0) ? 1 : 2);
      check("rr-time", (i < dn) ? dTimes[i] : 0, 43 + 44*i);
    end
    repeat (50) tick();

    // Minimum-parameter instance: write then read.
    bus1.req_esc = 1; doneAt = -1; csLow = 0; firstLow = -1;
    for (int n = 1; n <= 40 && doneAt < 0; n++) begin
      tick(); bus1.req_esc = 0;
      if (!bus1.CS_n) begin csLow++; if (firstLow < 0) firstLow = n; end
      if (bus1.done_esc) doneAt = n;
    end
    check("min-done-cycle", doneAt, 14);
    check("min-cs-low", csLow, 4);
    check("min-first-low", firstLow, 3);
    tick();
    bus1.req_lec = 1; bus1.ad_in = 8'h3C; doneAt = -1;
    for (int n = 1; n <= 40 && doneAt < 0; n++) begin
      tick(); bus1.req_lec = 0;
      if (bus1.done_lec) doneAt = n;
    end
    check("min-rd-done", doneAt, 14);
    check("min-rdata", bus1.rdata, 8'h3C);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bus0.req_lec = ($urandom_range(0, 3) == 0);
      bus0.req_esc = ($urandom_range(0, 3) == 0);
      bus0.addr    = 8'($urandom);
      bus0.wdata   = 8'($urandom);
      bus0.ad_in   = 8'($urandom);
      reset        = ($urandom_range(0, 699) == 0);
      tick();
    end
    reset = 0; bus0.req_lec = 0; bus0.req_esc = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
